// File: rtl/shift_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_pkg
//  Description : Shared op encodings, one-hot shifter select codes and the
//                sequencer state type.
//  Revision    : 1.0 - initial release
// ============================================================================
package shift_sequencer_pkg;

    // Operation encodings presented on in_op
    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_SLL  = 2'b01;
    localparam logic [1:0] OP_SRL  = 2'b10;
    localparam logic [1:0] OP_ROR  = 2'b11;

    // One-hot shifter controls {l,k,j,i}
    localparam logic [3:0] SEL_PASS = 4'b1000;
    localparam logic [3:0] SEL_SLL  = 4'b0100;
    localparam logic [3:0] SEL_SRL  = 4'b0010;
    localparam logic [3:0] SEL_ROR  = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Map an op code onto the single-step shifter control
    function automatic logic [3:0] op_to_sel(input logic [1:0] op);
        logic [3:0] sel;
        sel = SEL_PASS;
        case (op)
            OP_SLL:  sel = SEL_SLL;
            OP_SRL:  sel = SEL_SRL;
            OP_ROR:  sel = SEL_ROR;
            default: sel = SEL_PASS;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_sequencer_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer_shifter
//  Description : 4-bit single-step shifter steered by a one-hot select.
//                Lives beside the sequencer; the sequencer only drives it.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer_shifter
    import shift_sequencer_pkg::*;
(
    input  logic [3:0] sh_data,
    input  logic [3:0] sh_sel,
    output logic [3:0] sh_result
);

    // One bit of pass / shift / rotate per evaluation
    always_comb begin
        sh_result = sh_data;
        case (sh_sel)
            SEL_SLL:  sh_result = {sh_data[2:0], 1'b0};
            SEL_SRL:  sh_result = {1'b0, sh_data[3:1]};
            SEL_ROR:  sh_result = {sh_data[0], sh_data[3:1]};
            default:  sh_result = sh_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : shift_sequencer
//  Description : Iterates an external 1-bit shifter count times over a
//                latched 4-bit word, with valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_data,
    input  logic [1:0]       in_op,
    input  logic [CNT_W-1:0] in_count,
    output logic [3:0]       sh_data,
    output logic [3:0]       sh_sel,
    input  logic [3:0]       sh_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_data,
    output logic             busy
);

    state_t           r_state;
    logic [3:0]       r_work;
    logic [CNT_W-1:0] r_cnt;
    // Latched op, held in its one-hot shifter form; PASS outside RUN
    logic [3:0]       r_sel;
    logic             r_out_valid;
    logic             r_in_ready;
    logic             r_busy;

    // Sequencer FSM: all state and every control output registered here
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_work      <= 4'b0000;
            r_cnt       <= '0;
            r_sel       <= SEL_PASS;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work     <= in_data;
                        r_cnt      <= in_count;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        // Nothing to iterate: result is the input word
                        if ((in_count == '0) || (in_op == OP_PASS)) begin
                            r_state     <= DONE;
                            r_sel       <= SEL_PASS;
                            r_out_valid <= 1'b1;
                        end else begin
                            r_state <= RUN;
                            r_sel   <= op_to_sel(in_op);
                        end
                    end
                end
                RUN: begin
                    r_work <= sh_result;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    // Leave on the last step so the counter never wraps
                    if (r_cnt == CNT_W'(1)) begin
                        r_state     <= DONE;
                        r_sel       <= SEL_PASS;
                        r_out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Return to IDLE only; acceptance waits a cycle
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_sel       <= SEL_PASS;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_work;
    assign sh_data   = r_work;
    assign sh_sel    = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_shift_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shift_sequencer
//  Description : Directed, table-driven bench for shift_sequencer wired to
//                the one-hot shifter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_sequencer;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic [1:0] in_op;
    logic [2:0] in_count;
    logic [3:0] sh_data;
    logic [3:0] sh_sel;
    logic [3:0] sh_result;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] data;
        logic [1:0] op;
        logic [2:0] count;
        logic [3:0] exp_out;
        logic [3:0] exp_sel;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    shift_sequencer #(.CNT_W(3)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_op     (in_op),
        .in_count  (in_count),
        .sh_data   (sh_data),
        .sh_sel    (sh_sel),
        .sh_result (sh_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    shift_sequencer_shifter u_shifter (
        .sh_data   (sh_data),
        .sh_sel    (sh_sel),
        .sh_result (sh_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        chk("hs_in_ready", 32'(in_ready), 32'd1);
        chk("hs_out_valid", 32'(out_valid), 32'd0);
        chk("hs_busy", 32'(busy), 32'd0);
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        chk("pre_in_ready", 32'(in_ready), 32'd1);
        chk("pre_sel", 32'(sh_sel), 32'h8);
        in_valid = 1'b1;
        in_data  = v.data;
        in_op    = v.op;
        in_count = v.count;
        step();
        chk("latched_sh_data", 32'(sh_data), 32'(v.data));
        // Garbage on the inputs while busy must be ignored
        in_data  = ~v.data;
        in_op    = ~v.op;
        in_count = ~v.count;
        lat = 1;
        while (!out_valid && lat < 20) begin
            chk("run_sel", 32'(sh_sel), 32'(v.exp_sel));
            chk("run_in_ready", 32'(in_ready), 32'd0);
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(v.exp_lat));
        chk("out_data", 32'(out_data), 32'(v.exp_out));
        chk("done_sel", 32'(sh_sel), 32'h8);
        chk("done_busy", 32'(busy), 32'd1);
        in_valid = 1'b0;
        handshake();
    endtask

    initial begin
        //           data     op     cnt   out      run sel  lat
        vecs[0] = '{4'b0111, 2'b01, 3'd1, 4'b1110, 4'b0100, 2};
        vecs[1] = '{4'b1001, 2'b11, 3'd3, 4'b0011, 4'b0001, 4};
        vecs[2] = '{4'b1010, 2'b01, 3'd0, 4'b1010, 4'b1000, 1};
        vecs[3] = '{4'b1010, 2'b00, 3'd5, 4'b1010, 4'b1000, 1};
        vecs[4] = '{4'b1101, 2'b10, 3'd1, 4'b0110, 4'b0010, 2};
        vecs[5] = '{4'b0001, 2'b01, 3'd7, 4'b0000, 4'b0100, 8};
        vecs[6] = '{4'b1011, 2'b11, 3'd4, 4'b1011, 4'b0001, 5};
        vecs[7] = '{4'b1000, 2'b10, 3'd3, 4'b0001, 4'b0010, 4};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 4'b0000;
        in_op     = 2'b00;
        in_count  = 3'd0;
        out_ready = 1'b0;

        // Reset state
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sel", 32'(sh_sel), 32'h8);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_sh_data", 32'(sh_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i]);
        end

        // Backpressure: result held while consumer stalls
        in_valid = 1'b1;
        in_data  = 4'b1111;
        in_op    = 2'b10;
        in_count = 3'd2;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("bp_valid", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            in_data  = 4'(i);
            in_op    = 2'b01;
            in_count = 3'd1;
            step();
            chk("bp_hold_data", 32'(out_data), 32'h3);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        // Handshake edge with a request present: must not be taken
        in_valid  = 1'b1;
        in_data   = 4'b0101;
        out_ready = 1'b1;
        step();
        chk("bp_no_accept_in_ready", 32'(in_ready), 32'd1);
        chk("bp_no_accept_valid", 32'(out_valid), 32'd0);
        chk("bp_no_accept_data", 32'(out_data), 32'h3);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        chk("bp_idle_stays", 32'(in_ready), 32'd1);

        // Abort: reset during the third RUN cycle
        in_valid = 1'b1;
        in_data  = 4'b0001;
        in_op    = 2'b01;
        in_count = 3'd7;
        step();
        in_valid = 1'b0;
        chk("ab_run1_busy", 32'(busy), 32'd1);
        step();
        step();
        chk("ab_run3_sel", 32'(sh_sel), 32'h4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("ab_in_ready", 32'(in_ready), 32'd1);
        chk("ab_out_valid", 32'(out_valid), 32'd0);
        chk("ab_out_data", 32'(out_data), 32'h0);
        chk("ab_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("ab_no_valid", 32'(out_valid), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: CNT_W, 3, width of the step-count field (max 7 steps).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  request offered.
REQ-005 in_ready  output  1  block able to accept a request.
REQ-006 in_data  input  4  word to shift, bit 3 = A (MSB) ... bit 0 = D.
REQ-007 in_op  input  2  00 pass, 01 shift-left logical, 10 shift-right logical, 11 rotate-right.
REQ-008 in_count  input  CNT_W  number of single-bit steps.
REQ-009 sh_data  output  4  word driven into the downstream 4-bit shifter.
REQ-010 sh_sel  output  4  one-hot shifter control {l,k,j,i}: l=pass, k=SLL1, j=SRL1, i=ROR1.
REQ-011 sh_result  input  4  combinational result from the shifter for the current sh_data/sh_sel.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 out_data  output  4  final shifted word.
REQ-015 busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, RUN, DONE.
REQ-017 in_ready SHALL be 1 exactly when state is IDLE.
REQ-018 In IDLE, when in_valid=1, the block SHALL latch in_data into the work register and latch in_op and in_count.
REQ-019 On acceptance with in_count=0 or in_op=00, the next state SHALL be DONE with the work register equal to in_data.
REQ-020 On acceptance otherwise, the next state SHALL be RUN with the step counter equal to in_count.
REQ-021 sh_data SHALL always equal the work register.
REQ-022 In RUN, sh_sel SHALL be the one-hot code for the latched op: 01->0100, 10->0010, 11->0001.
REQ-023 In IDLE and DONE, sh_sel SHALL be 1000 (pass).
REQ-024 Each RUN cycle SHALL load sh_result into the work register and decrement the step counter.
REQ-025 When the step counter is 1 in RUN, the next state SHALL be DONE.
REQ-026 Latency SHALL be count+1 cycles from the acceptance edge to out_valid=1; it SHALL be 1 cycle for count 0 or op pass.
REQ-027 out_valid SHALL be 1 exactly in DONE, and out_data SHALL equal the work register.
REQ-028 out_data and out_valid SHALL hold stable until out_ready=1.
REQ-029 In DONE with out_ready=1, the next state SHALL be IDLE; a new request SHALL NOT be accepted in that same cycle.
REQ-030 in_valid SHALL be ignored outside IDLE; in_data, in_op and in_count changes mid-run SHALL have no effect.
REQ-031 A maximum count of 7 SHALL complete with no counter wrap.

Reset
REQ-032 While rst=1 at a clock edge, the block SHALL enter IDLE and clear the work register and counter to 0, giving out_valid=0, out_data=0000, busy=0, in_ready=1, sh_sel=1000, sh_data=0000.
REQ-033 rst during RUN or DONE SHALL abort the operation with no out_valid pulse; rst SHALL take priority over all other inputs.

Structure
REQ-034 A shared package SHALL hold the op encodings, the one-hot sel constants (SEL_PASS, SEL_SLL, SEL_SRL, SEL_ROR) and the state enum.
REQ-035 The shifter itself SHALL stay outside this module; the bench SHALL instantiate the existing 4-bit one-hot shifter as the sub-module wired to sh_data, sh_sel and sh_result.

Verification
REQ-036 Reset: hold rst high for 2 cycles -> in_ready=1, out_valid=0, sh_sel=1000, out_data=0000.
REQ-037 SLL: data 0111, op 01, count 1 -> out_valid after 2 cycles, out_data 1110.
REQ-038 ROR: data 1001, op 11, count 3 -> sh_sel=0001 for 3 cycles, out_data 0011 after 4 cycles.
REQ-039 Zero and pass: data 1010, count 0 -> out_data 1010 after 1 cycle; data 1010, op 00, count 5 -> same result.
REQ-040 Backpressure: data 1111, op 10, count 2, out_ready=0 for 5 cycles -> out_data 0011 held stable, in_ready=0; in_valid pulses are ignored until the handshake completes.
REQ-041 Abort: data 0001, op 01, count 7, rst asserted in the 3rd RUN cycle -> IDLE next cycle, no out_valid, out_data 0000.
